// File: rtl/car_pkg.sv
// Shared car-controller definitions: FSM state codes, detector bit positions
// and turn direction codes.
package car_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPIN  = 3'd1;
    localparam logic [2:0] ST_EXIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SPIN  = ST_SPIN,
        EXIT  = ST_EXIT,
        DONE  = ST_DONE,
        FAULT = ST_FAULT
    } state_t;

    localparam int DET_FRONT = 3;
    localparam int DET_BACK  = 2;
    localparam int DET_LEFT  = 1;
    localparam int DET_RIGHT = 0;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_L    = 2'b10;
    localparam logic [1:0] DIR_R    = 2'b01;
    localparam logic [1:0] DIR_U    = 2'b11;

    // U-turn spins twice as long as a plain 90-degree turn.
    function automatic logic is_uturn(input logic [1:0] dir);
        return dir == DIR_U;
    endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Handshake and command bundle between the semi-auto FSM (master) and the
// turn sequencer (slave).
interface turn_sequencer_if;
    logic       tick_ms;
    logic       start;
    logic       dir_left;
    logic       dir_right;
    logic       abort;
    logic [3:0] detectors;
    logic       turn_left;
    logic       turn_right;
    logic       move_forward;
    logic       busy;
    logic       finish_turning;
    logic       fault;

    modport master (
        output tick_ms, start, dir_left, dir_right, abort, detectors,
        input  turn_left, turn_right, move_forward, busy, finish_turning, fault
    );

    modport slave (
        input  tick_ms, start, dir_left, dir_right, abort, detectors,
        output turn_left, turn_right, move_forward, busy, finish_turning, fault
    );
endinterface

// File: rtl/ms_down_counter.sv
// Millisecond down-counter: loadable, decrements on tick, saturates at zero.
module ms_down_counter #(
    parameter int CNT_W = 12
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over tick so a strobe in the loading cycle is never counted.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: timed spin, forward exit run, then a one-cycle
// finish_turning pulse. Moore outputs, all registered.
module turn_sequencer
    import car_pkg::*;
#(
    parameter int TURN_MS = 900,
    parameter int EXIT_MS = 300,
    parameter int CNT_W   = 12
) (
    input  logic             sys_clk,
    input  logic             rst,
    turn_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_MS - 1);
    localparam logic [CNT_W-1:0] UTRN_LOAD = CNT_W'(2 * TURN_MS - 1);
    localparam logic [CNT_W-1:0] EXIT_LOAD = CNT_W'(EXIT_MS - 1);

    state_t           st_q, st_d;
    logic [1:0]       dir_q, dir_d;
    logic             fault_q, fault_d;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_tick;
    logic             front;
    logic             last_tick;

    logic turn_left_q, turn_right_q, move_forward_q, busy_q, finish_q;

    assign front     = bus.detectors[DET_FRONT];
    assign cnt_tick  = bus.tick_ms && ((st_q == SPIN) || (st_q == EXIT));
    // Strobe that arrives with the counter already at zero closes a timed phase.
    assign last_tick = bus.tick_ms && cnt_zero && (cnt == '0);

    ms_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .tick     (cnt_tick),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Next-state, direction latch, fault flag and counter load decisions.
    always_comb begin
        st_d    = st_q;
        dir_d   = dir_q;
        fault_d = fault_q;
        ld      = 1'b0;
        ld_val  = '0;
        case (st_q)
            IDLE: begin
                // abort beats start; a start with no direction is ignored
                if (!bus.abort && bus.start && (bus.dir_left || bus.dir_right)) begin
                    dir_d   = {bus.dir_left, bus.dir_right};
                    ld      = 1'b1;
                    ld_val  = is_uturn({bus.dir_left, bus.dir_right}) ? UTRN_LOAD : TURN_LOAD;
                    fault_d = 1'b0;
                    st_d    = SPIN;
                end
            end
            SPIN: begin
                if (bus.abort) begin
                    st_d = IDLE;
                end else if (last_tick) begin
                    if (front) begin
                        fault_d = 1'b1;
                        st_d    = FAULT;
                    end else begin
                        ld     = 1'b1;
                        ld_val = EXIT_LOAD;
                        st_d   = EXIT;
                    end
                end
            end
            EXIT: begin
                if (bus.abort) begin
                    st_d = IDLE;
                end else if (front) begin
                    fault_d = 1'b1;
                    st_d    = FAULT;
                end else if (last_tick) begin
                    st_d = DONE;
                end
            end
            DONE:    st_d = IDLE;
            FAULT:   st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // State registers plus outputs decoded from the next state, so each output
    // is a flop that mirrors the state it belongs to.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            st_q           <= IDLE;
            dir_q          <= DIR_NONE;
            fault_q        <= 1'b0;
            turn_left_q    <= 1'b0;
            turn_right_q   <= 1'b0;
            move_forward_q <= 1'b0;
            busy_q         <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            st_q           <= st_d;
            dir_q          <= dir_d;
            fault_q        <= fault_d;
            // U-turn spins left; turn bits are never both set
            turn_left_q    <= (st_d == SPIN) && dir_d[1];
            turn_right_q   <= (st_d == SPIN) && (dir_d == DIR_R);
            move_forward_q <= (st_d == EXIT);
            busy_q         <= (st_d != IDLE);
            finish_q       <= (st_d == DONE);
        end
    end

    assign bus.turn_left      = turn_left_q;
    assign bus.turn_right     = turn_right_q;
    assign bus.move_forward   = move_forward_q;
    assign bus.busy           = busy_q;
    assign bus.finish_turning = finish_q;
    assign bus.fault          = fault_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with TURN_MS=4, EXIT_MS=2, tick every 10 cycles.
module tb_turn_sequencer;
    import car_pkg::*;

    typedef struct {
        logic [1:0] dir;
        int         l_ticks;
        int         r_ticks;
        int         ex_ticks;
        int         pulses;
    } vec_t;

    typedef struct {
        int l, r, ex, pl, both, busy_after, faults, timeout;
    } res_t;

    logic sys_clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;

    always #5 sys_clk = ~sys_clk;

    turn_sequencer_if bus ();

    turn_sequencer #(.TURN_MS(4), .EXIT_MS(2), .CNT_W(12)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge, and the
    // tick strobe for the coming edge is presented here.
    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        bus.tick_ms = (cyc % 10 == 0);
    endtask

    function automatic int outs();
        return {bus.turn_left, bus.turn_right, bus.move_forward,
                bus.busy, bus.finish_turning, bus.fault};
    endfunction

    // Issue one turn and observe it until busy drops.
    task automatic run_turn(input logic [1:0] dir, input bit align, input int repulse_at,
                            output res_t r);
        bit prev_fin;
        r = '{default: 0};
        r.busy_after = -1;
        if (align) begin
            for (int i = 0; i < 20 && !bus.tick_ms; i++) step();
        end
        bus.dir_left  = dir[1];
        bus.dir_right = dir[0];
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        prev_fin  = 1'b0;
        r.timeout = 1;
        for (int c = 0; c < 400; c++) begin
            if (c == repulse_at) begin
                bus.start = 1'b1; bus.dir_left = 1'b0; bus.dir_right = 1'b1;
            end else if (c == repulse_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.turn_left && bus.tick_ms)    r.l++;
            if (bus.turn_right && bus.tick_ms)   r.r++;
            if (bus.move_forward && bus.tick_ms) r.ex++;
            if (bus.turn_left && bus.turn_right) r.both++;
            if (bus.finish_turning)              r.pl++;
            if (bus.fault)                       r.faults++;
            if (prev_fin) r.busy_after = int'(bus.busy);
            prev_fin = bus.finish_turning;
            if (!bus.busy) begin
                r.timeout = 0;
                break;
            end
            step();
        end
        bus.start = 1'b0;
    endtask

    task automatic wait_mf(input string nm);
        int i;
        for (i = 0; i < 300 && !bus.move_forward; i++) step();
        chk({nm, "_reach_exit"}, int'(bus.move_forward), 1);
    endtask

    // Right turn whose exit gets blocked by the front detector.
    task automatic do_block(input string nm);
        bus.dir_left = 1'b0; bus.dir_right = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_mf(nm);
        bus.detectors = 4'b1000;
        step();
        chk({nm, "_mf_off"},  int'(bus.move_forward), 0);
        chk({nm, "_fault"},   int'(bus.fault), 1);
        chk({nm, "_no_fin"},  int'(bus.finish_turning), 0);
        bus.detectors = 4'b0000;
        step();
        chk({nm, "_idle"},    int'(bus.busy), 0);
    endtask

    initial begin
        vec_t tbl[3];
        res_t r;
        int   n;

        tbl[0] = '{DIR_L, 4, 0, 2, 1};
        tbl[1] = '{DIR_R, 0, 4, 2, 1};
        tbl[2] = '{DIR_U, 8, 0, 2, 1};

        bus.tick_ms = 1'b0; bus.start = 1'b0; bus.dir_left = 1'b0;
        bus.dir_right = 1'b0; bus.abort = 1'b0; bus.detectors = 4'b0000;
        rst = 1'b1;
        step();
        chk("reset_outs", outs(), 0);
        step();
        rst = 1'b0;
        step();

        // table-driven complete turns
        foreach (tbl[i]) begin
            run_turn(tbl[i].dir, 1'b0, -1, r);
            chk($sformatf("v%0d_timeout", i),    r.timeout, 0);
            chk($sformatf("v%0d_left_ticks", i), r.l, tbl[i].l_ticks);
            chk($sformatf("v%0d_right_ticks", i), r.r, tbl[i].r_ticks);
            chk($sformatf("v%0d_exit_ticks", i), r.ex, tbl[i].ex_ticks);
            chk($sformatf("v%0d_pulses", i),     r.pl, tbl[i].pulses);
            chk($sformatf("v%0d_both_turn", i),  r.both, 0);
            chk($sformatf("v%0d_busy_after", i), r.busy_after, 0);
            chk($sformatf("v%0d_fault", i),      r.faults, 0);
            step(); step();
        end

        // start with no direction is ignored
        bus.dir_left = 1'b0; bus.dir_right = 1'b0; bus.start = 1'b1;
        step(); step();
        chk("dir00_ignored", int'(bus.busy), 0);
        bus.start = 1'b0;
        step();

        // abort together with start in IDLE wins
        bus.dir_left = 1'b1; bus.start = 1'b1; bus.abort = 1'b1;
        step();
        chk("start_abort_busy", int'(bus.busy), 0);
        bus.start = 1'b0; bus.abort = 1'b0;
        step();
        chk("start_abort_idle", int'(bus.busy), 0);

        // abort mid-spin after two ticks
        bus.dir_left = 1'b1; bus.dir_right = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            if (bus.turn_left && bus.tick_ms) n++;
            if (n < 2) step();
        end
        step();
        chk("abort_spinning", int'(bus.turn_left), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_outs", outs(), 0);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.finish_turning || bus.busy) n++;
            step();
        end
        chk("abort_quiet", n, 0);

        // blocked exit, fault sticky through idle
        do_block("blk1");
        for (int c = 0; c < 5; c++) step();
        chk("blk1_sticky", int'(bus.fault), 1);

        // reset clears the sticky fault
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clears_fault", outs(), 0);
        step();

        // the next accepted start clears the fault and runs to completion
        do_block("blk2");
        chk("blk2_sticky", int'(bus.fault), 1);
        run_turn(DIR_L, 1'b0, -1, r);
        chk("clr_fault_seen", r.faults, 0);
        chk("clr_pulses", r.pl, 1);
        step();

        // reset mid-exit
        bus.dir_left = 1'b0; bus.dir_right = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_mf("rstx");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_exit_outs", outs(), 0);
        step();
        chk("rst_exit_idle", int'(bus.busy), 0);

        // start re-pulsed with a different direction while busy
        run_turn(DIR_L, 1'b0, 15, r);
        chk("repulse_left", r.l, 4);
        chk("repulse_right", r.r, 0);
        chk("repulse_exit", r.ex, 2);
        chk("repulse_pulse", r.pl, 1);
        step();

        // tick coincident with the start-accept cycle
        run_turn(DIR_L, 1'b1, -1, r);
        chk("bnd_timeout", r.timeout, 0);
        chk("bnd_left", r.l, 4);
        chk("bnd_exit", r.ex, 2);
        chk("bnd_pulse", r.pl, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Controller that sequences the car's motion commands through a semi-automatic turn at a fork.
- Start with a timed left, right or U-turn spin. Then a forward exit run so the fork detector does not re-trigger. Finish with a one-cycle finish_turning pulse.
- Sits between the top-level semi-auto FSM, which issues start/dir while in its turning state, and the UART command byte, which receives turn_left/turn_right/move_forward.
- Millisecond timing comes from a strobe derived by the clock divider.

Parameters:
- TURN_MS, 900, tick_ms strobes spent spinning for a 90-degree turn; U-turn uses 2*TURN_MS.
- EXIT_MS, 300, tick_ms strobes of forward motion after the spin.
- CNT_W, 12, ms counter width; must hold 2*TURN_MS-1 and EXIT_MS-1.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- rst  in  1  reset.
- tick_ms  in  1  one-sys_clk-wide strobe, once per ms.
- start  in  1  request a turn; sampled only in IDLE.
- dir_left  in  1  turn direction, sampled with start.
- dir_right  in  1  turn direction, sampled with start; dir_left and dir_right both high means U-turn.
- abort  in  1  cancel the sequence immediately.
- detectors  in  4  {front, back, left, right} obstacle detectors; 1 = obstacle.
- turn_left  out  1  command bit to the UART byte.
- turn_right  out  1  command bit to the UART byte.
- move_forward  out  1  command bit to the UART byte.
- busy  out  1  high in any state other than IDLE.
- finish_turning  out  1  one-cycle pulse on successful completion.
- fault  out  1  sticky: set when the exit is blocked; cleared by the next accepted start or by rst.

Behaviour:
Clock and reset:
- One clock, sys_clk. Reset rst is synchronous and active-high.
- On a rst sample: state=IDLE, counter=0, dir register=00, fault=0.
- All outputs are 0 in the cycle after the rst sample.
- rst has priority over every other input.

Output style:
- Moore. Outputs are decoded from registered state only, with no input-to-output combinational path.

States (3-bit encoding):
- IDLE
- SPIN
- EXIT
- DONE
- FAULT

IDLE:
- All motion outputs 0.
- Accept a start only when start=1 and (dir_left|dir_right)=1.
- On accept: latch dir, load counter with TURN_MS-1 (U-turn: 2*TURN_MS-1), clear fault, go to SPIN next cycle.
- A start with dir=00 is ignored; stay in IDLE and leave fault unchanged.

SPIN:
- Left: turn_left=1. Right: turn_right=1.
- U-turn: turn_left=1. Both turn bits are never 1 together.
- move_forward=0.
- Counter decrements only on tick_ms. A tick_ms while counter=0 ends the spin.
- At that point, if detectors[3] (front)=1, go to FAULT. Otherwise load EXIT_MS-1 and go to EXIT.

EXIT:
- move_forward=1, turn bits 0.
- A tick_ms at counter=0 moves to DONE.
- front=1 sampled in any EXIT cycle moves to FAULT; motion stops the next cycle.

DONE:
- finish_turning=1 for exactly one cycle, all motion outputs 0, then IDLE.
- busy=1 in DONE.

FAULT:
- Set fault=1, motion outputs 0, return to IDLE the next cycle.

Spin length:
- Spin lasts TURN_MS tick_ms strobes, measured from the first strobe after entry.
- The partial ms before that first strobe is additional.

Inputs ignored while busy:
- start and dir changes are ignored while busy; dir is held in a register.

abort:
- In any busy state, abort=1 returns to IDLE on the next cycle.
- All outputs go to 0, no finish_turning pulse, fault unchanged.
- abort in the DONE cycle still suppresses nothing: the pulse is already out.
- abort in IDLE has no effect.
- abort together with start in IDLE: abort wins and start is not accepted.

Simultaneous events:
- A tick_ms in the same cycle a state is entered is ignored; the counter was just loaded.

Decomposition:
- Shared package car_pkg:
  - state encodings IDLE..FAULT (3-bit localparams);
  - detector bit indices DET_FRONT=3, DET_BACK=2, DET_LEFT=1, DET_RIGHT=0;
  - direction codes DIR_L=2'b10, DIR_R=2'b01, DIR_U=2'b11.
- One sub-module, ms_down_counter (CNT_W):
  - ports: load, load_val, tick, count, zero;
  - load has priority over tick.
- The FSM and the output decode stay in turn_sequencer.

Test Plan:
Common setup: TURN_MS=4, EXIT_MS=2, tick_ms every 10 cycles, detectors=0 unless stated.
- Left turn: start=1, dir=10 in IDLE -> turn_left=1 from the next cycle for 4 ticks; then move_forward=1 for 2 ticks; then finish_turning high exactly 1 cycle; busy falls the cycle after.
- U-turn: dir=11 -> turn_left=1 for 8 ticks, turn_right never 1; then exit and a single finish_turning pulse.
- Blocked exit: right turn, front=1 raised during EXIT -> move_forward=0 next cycle, fault=1 and sticky, no finish_turning; the next valid start clears fault.
- Abort: abort pulsed mid-SPIN after 2 ticks -> all outputs 0 next cycle, state IDLE, no pulse; start+abort together in IDLE -> not accepted.
- Reset: rst asserted mid-EXIT -> all outputs 0 the next cycle, fault=0; start with dir=00 -> stays IDLE; start re-pulsed while busy -> timing unchanged.
- Boundary: tick_ms coincident with the start-accept cycle -> spin still lasts 4 subsequent ticks.
